// File: rtl/amber_wb_pkg.sv
// Shared types and helpers for the Amber Wishbone responder.
package amber_wb_pkg;

    localparam int unsigned ADR_W  = 32;
    localparam int unsigned SEL_W  = 16;
    localparam int unsigned BUS_W  = 128;
    localparam int unsigned INST_W = 32;

    localparam logic [INST_W-1:0] FILL_WORD_DEF = 32'hF080_1003;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_state_e;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [SEL_W-1:0] sel;
        logic             we;
        logic [BUS_W-1:0] dat;
    } wb_req_t;

    // Replace the bytes of old_w selected by sel with the matching bytes of new_w.
    function automatic logic [BUS_W-1:0] byte_merge(input logic [BUS_W-1:0] old_w,
                                                    input logic [BUS_W-1:0] new_w,
                                                    input logic [SEL_W-1:0] sel);
        logic [BUS_W-1:0] r;
        r = old_w;
        for (int b = 0; b < int'(SEL_W); b++) begin
            if (sel[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/amber_inst_fifo.sv
// Instruction word FIFO: bench pushes words, the responder pops one per acked fetch.
module amber_inst_fifo
    import amber_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = INST_W
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [WIDTH-1:0]               data_i,
    input  logic                           pop_i,
    output logic [WIDTH-1:0]               head_o,
    output logic                           ready_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             push_ok;
    logic             pop_ok;

    // Ready is judged on the occupancy before any same-cycle pop.
    assign ready_o = (level_q != LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i & ready_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    // Storage array, contents not reset.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/amber_wb_responder.sv
// Wishbone B3 classic slave for the Amber 128-bit bus: instruction FIFO window,
// byte-writable data RAM window, and a write capture port.
module amber_wb_responder
    import amber_wb_pkg::*;
#(
    parameter int unsigned       FIFO_DEPTH  = 8,
    parameter logic [INST_W-1:0] FILL_WORD   = FILL_WORD_DEF,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [ADR_W-1:0]  DATA_BASE   = 32'h0000_1000,
    parameter int unsigned       RAM_WORDS   = 64
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [ADR_W-1:0]                  i_wb_adr,
    input  logic [SEL_W-1:0]                  i_wb_sel,
    input  logic                              i_wb_we,
    input  logic [BUS_W-1:0]                  i_wb_dat,
    input  logic                              i_wb_cyc,
    input  logic                              i_wb_stb,
    output logic [BUS_W-1:0]                  o_wb_dat,
    output logic                              o_wb_ack,
    output logic                              o_wb_err,
    input  logic                              i_inst_valid,
    input  logic [INST_W-1:0]                 i_inst,
    output logic                              o_inst_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_fifo_level,
    output logic                              o_underrun,
    output logic                              o_wr_valid,
    output logic [ADR_W-1:0]                  o_wr_adr,
    output logic [SEL_W-1:0]                  o_wr_sel,
    output logic [BUS_W-1:0]                  o_wr_dat
);

    localparam int unsigned IDX_W  = $clog2(RAM_WORDS);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned WORD_W = ADR_W - 4;

    wb_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    wb_req_t            req_q, req_d, req_in;
    logic               ack_q, ack_d, err_q, err_d;
    logic [BUS_W-1:0]   dat_q, dat_d;
    logic               pop_q, pop_d, wr_q, wr_d, und_q, und_d;
    logic               underrun_q, underrun_d;
    logic               wr_valid_q, wr_valid_d;
    logic [ADR_W-1:0]   wr_adr_q, wr_adr_d;
    logic [SEL_W-1:0]   wr_sel_q, wr_sel_d;
    logic [BUS_W-1:0]   wr_dat_q, wr_dat_d;
    logic [BUS_W-1:0]   ram_q [RAM_WORDS];

    logic               bus_req, commit, resp_go;
    logic [ADR_W-1:0]   cur_adr;
    logic               cur_we, inst_win, in_range;
    logic [WORD_W-1:0]  word_idx;
    logic [IDX_W-1:0]   ram_idx;
    logic [INST_W-1:0]  fifo_head;
    logic               fifo_empty;

    // In IDLE the response is decided straight from the bus; later from the latched request.
    assign req_in   = '{adr: i_wb_adr, sel: i_wb_sel, we: i_wb_we, dat: i_wb_dat};
    assign cur_adr  = (state_q == IDLE) ? i_wb_adr : req_q.adr;
    assign cur_we   = (state_q == IDLE) ? i_wb_we  : req_q.we;
    assign bus_req  = i_wb_cyc & i_wb_stb;
    assign inst_win = (cur_adr < DATA_BASE);
    assign word_idx = cur_adr[ADR_W-1:4] - DATA_BASE[ADR_W-1:4];
    assign in_range = (word_idx < WORD_W'(RAM_WORDS));
    assign ram_idx  = word_idx[IDX_W-1:0];
    // Side effects land only if the master is still holding the strobe through the ack cycle.
    assign commit   = (state_q == RESP) & bus_req;

    amber_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .push_i  (i_inst_valid),
        .data_i  (i_inst),
        .pop_i   (commit & pop_q),
        .head_o  (fifo_head),
        .ready_o (o_inst_ready),
        .empty_o (fifo_empty),
        .level_o (o_fifo_level)
    );

    // Next-state, response decode and write capture.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        dat_d      = '0;
        pop_d      = 1'b0;
        wr_d       = 1'b0;
        und_d      = 1'b0;
        resp_go    = 1'b0;
        underrun_d = underrun_q | (commit & und_q);
        wr_valid_d = commit & wr_q;
        wr_adr_d   = wr_adr_q;
        wr_sel_d   = wr_sel_q;
        wr_dat_d   = wr_dat_q;

        case (state_q)
            IDLE: begin
                if (bus_req) begin
                    req_d = req_in;
                    if (WAIT_STATES == 0) begin
                        resp_go = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            WAIT: begin
                if (!bus_req)                    state_d = IDLE;
                else if (cnt_q == CNT_W'(1))     resp_go = 1'b1;
                else                             cnt_d   = cnt_q - CNT_W'(1);
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (resp_go) begin
            state_d = RESP;
            if (inst_win) begin
                if (cur_we) begin
                    err_d = 1'b1;
                end else if (fifo_empty) begin
                    ack_d = 1'b1;
                    dat_d = {4{FILL_WORD}};
                    und_d = 1'b1;
                end else begin
                    ack_d = 1'b1;
                    dat_d = {FILL_WORD, FILL_WORD, FILL_WORD, fifo_head};
                    pop_d = 1'b1;
                end
            end else if (!in_range) begin
                err_d = 1'b1;
            end else begin
                ack_d = 1'b1;
                if (cur_we) wr_d  = 1'b1;
                else        dat_d = ram_q[ram_idx];
            end
        end

        if (commit & wr_q) begin
            wr_adr_d = req_q.adr;
            wr_sel_d = req_q.sel;
            wr_dat_d = req_q.dat;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
            pop_q      <= 1'b0;
            wr_q       <= 1'b0;
            und_q      <= 1'b0;
            underrun_q <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_adr_q   <= '0;
            wr_sel_q   <= '0;
            wr_dat_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            dat_q      <= dat_d;
            pop_q      <= pop_d;
            wr_q       <= wr_d;
            und_q      <= und_d;
            underrun_q <= underrun_d;
            wr_valid_q <= wr_valid_d;
            wr_adr_q   <= wr_adr_d;
            wr_sel_q   <= wr_sel_d;
            wr_dat_q   <= wr_dat_d;
        end
    end

    // Data RAM byte merge on a committed write; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (commit & wr_q) ram_q[ram_idx] <= byte_merge(ram_q[ram_idx], req_q.dat, req_q.sel);
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_err   = err_q;
    assign o_wb_dat   = dat_q;
    assign o_underrun = underrun_q;
    assign o_wr_valid = wr_valid_q;
    assign o_wr_adr   = wr_adr_q;
    assign o_wr_sel   = wr_sel_q;
    assign o_wr_dat   = wr_dat_q;

endmodule

// File: tb/tb_amber_wb_responder.sv
// Bench for amber_wb_responder: transaction-level model for a zero-wait instance,
// directed latency/abort vectors for a three-wait-state instance.
module tb_amber_wb_responder;

    localparam logic [31:0] FILL  = 32'hF0801003;
    localparam int          DEPTH = 8;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic         i_wb_we;
    logic [127:0] i_wb_dat;
    logic         i_wb_cyc, i_wb_stb, i_inst_valid;
    logic [31:0]  i_inst;
    logic         cyc3, stb3, iv3;

    logic [127:0] o_wb_dat, o_wr_dat, d3_dat, d3_wr_dat;
    logic         o_wb_ack, o_wb_err, o_inst_ready, o_underrun, o_wr_valid;
    logic         d3_ack, d3_err, d3_ready, d3_und, d3_wrv;
    logic [3:0]   o_fifo_level, d3_level;
    logic [31:0]  o_wr_adr, d3_wr_adr;
    logic [15:0]  o_wr_sel, d3_wr_sel;

    amber_wb_responder #(.WAIT_STATES(0)) dut0 (
        .i_clk(i_clk), .i_rst(i_rst), .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .i_inst_valid(i_inst_valid), .i_inst(i_inst), .o_inst_ready(o_inst_ready),
        .o_fifo_level(o_fifo_level), .o_underrun(o_underrun), .o_wr_valid(o_wr_valid),
        .o_wr_adr(o_wr_adr), .o_wr_sel(o_wr_sel), .o_wr_dat(o_wr_dat));

    amber_wb_responder #(.WAIT_STATES(3)) dut3 (
        .i_clk(i_clk), .i_rst(i_rst), .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel),
        .i_wb_we(i_wb_we), .i_wb_dat(i_wb_dat), .i_wb_cyc(cyc3), .i_wb_stb(stb3),
        .o_wb_dat(d3_dat), .o_wb_ack(d3_ack), .o_wb_err(d3_err),
        .i_inst_valid(iv3), .i_inst(i_inst), .o_inst_ready(d3_ready),
        .o_fifo_level(d3_level), .o_underrun(d3_und), .o_wr_valid(d3_wrv),
        .o_wr_adr(d3_wr_adr), .o_wr_sel(d3_wr_sel), .o_wr_dat(d3_wr_dat));

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Model of the zero-wait instance.
    logic [31:0]  mq[$];
    logic [127:0] mram [64];
    logic         m_und;
    logic [31:0]  m_wadr;
    logic [15:0]  m_wsel;
    logic [127:0] m_wdat;
    logic         exp_ack, exp_err, exp_wrv;
    logic [127:0] exp_dat;
    logic         chk_en;
    bit           pend, p_pop, p_und, p_wr;
    int           p_idx;
    logic [31:0]  p_adr;
    logic [15:0]  p_sel;
    logic [127:0] p_dat;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] merge(input logic [127:0] o, input logic [127:0] n,
                                           input logic [15:0] s);
        logic [127:0] r;
        r = o;
        for (int b = 0; b < 16; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        return r;
    endfunction

    // Per-cycle comparison of the zero-wait instance against the model.
    always @(negedge i_clk) begin
        if (chk_en) begin
            chk("ack",      128'(o_wb_ack),     128'(exp_ack));
            chk("err",      128'(o_wb_err),     128'(exp_err));
            chk("rdat",     o_wb_dat,           exp_dat);
            chk("level",    128'(o_fifo_level), 128'(mq.size()));
            chk("ready",    128'(o_inst_ready), 128'(mq.size() < DEPTH));
            chk("underrun", 128'(o_underrun),   128'(m_und));
            chk("wr_valid", 128'(o_wr_valid),   128'(exp_wrv));
            chk("wr_adr",   128'(o_wr_adr),     128'(m_wadr));
            chk("wr_sel",   128'(o_wr_sel),     128'(m_wsel));
            chk("wr_dat",   o_wr_dat,           m_wdat);
        end
    end

    // Advance one clock; apply whatever the model says the edge does.
    task automatic tick();
        bit          do_push;
        logic [31:0] w;
        do_push = (i_inst_valid === 1'b1) && (mq.size() < DEPTH);
        w       = i_inst;
        @(posedge i_clk);
        #1;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        exp_dat = '0;
        exp_wrv = 1'b0;
        if (do_push) mq.push_back(w);
        if (pend) begin
            pend = 1'b0;
            if (p_pop) void'(mq.pop_front());
            if (p_und) m_und = 1'b1;
            if (p_wr) begin
                mram[p_idx] = merge(mram[p_idx], p_dat, p_sel);
                exp_wrv = 1'b1;
                m_wadr  = p_adr;
                m_wsel  = p_sel;
                m_wdat  = p_dat;
            end
        end
    endtask

    // Present a request; returns in the response cycle.
    task automatic start(input logic [31:0] adr, input logic we, input logic [15:0] sel,
                         input logic [127:0] dat);
        logic         r_ack, r_err;
        logic [127:0] r_dat;
        int           idx;
        i_wb_adr = adr; i_wb_we = we; i_wb_sel = sel; i_wb_dat = dat;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
        r_ack = 1'b0; r_err = 1'b0; r_dat = '0;
        p_pop = 1'b0; p_und = 1'b0; p_wr = 1'b0;
        if (adr < 32'h1000) begin
            if (we) r_err = 1'b1;
            else if (mq.size() > 0) begin
                r_ack = 1'b1; r_dat = {FILL, FILL, FILL, mq[0]}; p_pop = 1'b1;
            end else begin
                r_ack = 1'b1; r_dat = {4{FILL}}; p_und = 1'b1;
            end
        end else begin
            idx = int'((adr - 32'h1000) >> 4);
            if (idx >= 64) r_err = 1'b1;
            else begin
                r_ack = 1'b1;
                if (we) begin
                    p_wr = 1'b1; p_idx = idx; p_adr = adr; p_sel = sel; p_dat = dat;
                end else begin
                    r_dat = mram[idx];
                end
            end
        end
        tick();
        exp_ack = r_ack;
        exp_err = r_err;
        exp_dat = r_dat;
        pend    = 1'b1;
    endtask

    // Hold the strobe through the response cycle, then release the bus.
    task automatic close_acc(input bit push_b);
        if (push_b) i_inst_valid = 1'b1;
        tick();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0; i_inst_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        i_inst = w; i_inst_valid = 1'b1;
        tick();
        i_inst_valid = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1; chk_en = 1'b0; pend = 1'b0;
        i_wb_adr = '0; i_wb_sel = '0; i_wb_we = 1'b0; i_wb_dat = '0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_inst_valid = 1'b0; i_inst = '0;
        cyc3 = 1'b0; stb3 = 1'b0; iv3 = 1'b0;
        m_und = 1'b0; m_wadr = '0; m_wsel = '0; m_wdat = '0;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_wrv = 1'b0;
        for (int i = 0; i < 64; i++) mram[i] = '0;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_ack",   128'({o_wb_ack, o_wb_err, o_underrun, o_wr_valid}), 128'd0);
        chk("rst_level", 128'(o_fifo_level), 128'd0);
        chk("rst_ready", 128'(o_inst_ready), 128'd1);
        chk("rst_rdat",  o_wb_dat, 128'd0);
        i_rst = 1'b0; chk_en = 1'b1;
        tick();

        // 1: single fetch with a loaded word
        push_word(32'hE0812003);
        chk("t1_level_pre", 128'(o_fifo_level), 128'd1);
        start(32'h0000_0000, 1'b0, 16'hFFFF, '0);
        chk("t1_ack", 128'(o_wb_ack), 128'd1);
        chk("t1_dat", o_wb_dat, 128'hF0801003F0801003F0801003E0812003);
        close_acc(1'b0);
        chk("t1_level_post", 128'(o_fifo_level), 128'd0);

        // 2: fetch from an empty FIFO
        start(32'h0000_0010, 1'b0, 16'hFFFF, '0);
        chk("t2_dat", o_wb_dat, 128'hF0801003F0801003F0801003F0801003);
        close_acc(1'b0);
        chk("t2_underrun", 128'(o_underrun), 128'd1);

        // 3: byte-lane write merge
        start(32'h0000_1000, 1'b1, 16'hFFFF, 128'h00112233445566778899AABBCCDDEEFF);
        close_acc(1'b0);
        start(32'h0000_1000, 1'b1, 16'h000F, 128'h111111111111111111111111DEADBEEF);
        close_acc(1'b0);
        chk("t3_wrv", 128'(o_wr_valid), 128'd1);
        chk("t3_wsel", 128'(o_wr_sel), 128'h000F);
        tick();
        start(32'h0000_1000, 1'b0, 16'hFFFF, '0);
        chk("t3_rdat", o_wb_dat, 128'h00112233445566778899AABBDEADBEEF);
        close_acc(1'b0);

        // sel=0 write leaves the word unchanged
        start(32'h0000_1010, 1'b1, 16'hFFFF, 128'hCAFEF00D0123456789ABCDEF13579BDF);
        close_acc(1'b0);
        start(32'h0000_1010, 1'b1, 16'h0000, {4{32'hFFFFFFFF}});
        close_acc(1'b0);
        start(32'h0000_101C, 1'b0, 16'hFFFF, '0);
        chk("t3_sel0", o_wb_dat, 128'hCAFEF00D0123456789ABCDEF13579BDF);
        close_acc(1'b0);

        // 5: error responses
        start(32'h0000_0000, 1'b1, 16'hFFFF, {4{32'h55555555}});
        chk("t5_werr", 128'({o_wb_ack, o_wb_err}), 128'b01);
        close_acc(1'b0);
        start(32'h0000_1400, 1'b0, 16'hFFFF, '0);
        chk("t5_rerr", 128'({o_wb_ack, o_wb_err}), 128'b01);
        close_acc(1'b0);
        start(32'h0000_13F0, 1'b0, 16'hFFFF, '0);
        close_acc(1'b0);
        start(32'h0000_1400, 1'b1, 16'hFFFF, '1);
        close_acc(1'b0);

        // 6: full FIFO, push and pop in the same cycle
        for (int i = 0; i < DEPTH; i++) push_word(32'hA000_0000 + 32'(i));
        chk("t6_full_level", 128'(o_fifo_level), 128'd8);
        chk("t6_full_ready", 128'(o_inst_ready), 128'd0);
        i_inst = 32'hBBBB_BBBB;
        start(32'h0000_0020, 1'b0, 16'hFFFF, '0);
        chk("t6_head", o_wb_dat, 128'hF0801003F0801003F0801003A0000000);
        close_acc(1'b1);
        chk("t6_level", 128'(o_fifo_level), 128'd7);
        chk("t6_ready", 128'(o_inst_ready), 128'd1);
        for (int i = 0; i < 7; i++) begin
            start(32'h0000_0000, 1'b0, 16'hFFFF, '0);
            close_acc(1'b0);
        end

        // 4: three wait states, abort in the wait phase
        i_inst = 32'h1234_5678; iv3 = 1'b1;
        tick();
        iv3 = 1'b0;
        chk("t4_lvl_pre", 128'(d3_level), 128'd1);
        i_wb_adr = 32'h0; i_wb_we = 1'b0; cyc3 = 1'b1; stb3 = 1'b1;
        tick(); tick();
        stb3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_noack", 128'({d3_ack, d3_err}), 128'd0);
        end
        cyc3 = 1'b0;
        chk("t4_lvl", 128'(d3_level), 128'd1);
        i_wb_adr = 32'h1000; i_wb_we = 1'b1; i_wb_sel = 16'hFFFF; i_wb_dat = {4{32'h77777777}};
        cyc3 = 1'b1; stb3 = 1'b1;
        tick(); tick(); tick();
        cyc3 = 1'b0; stb3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("t4_nowr", 128'({d3_wrv, d3_ack, d3_err}), 128'd0);
        end
        i_wb_we = 1'b0; i_wb_adr = 32'h0; cyc3 = 1'b1; stb3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("t4_lat_wait", 128'(d3_ack), 128'd0);
        end
        tick();
        chk("t4_lat_ack", 128'({d3_ack, d3_err}), 128'b10);
        chk("t4_lat_dat", d3_dat, 128'hF0801003F0801003F0801003_12345678);
        tick();
        cyc3 = 1'b0; stb3 = 1'b0;
        chk("t4_lvl_post", 128'({d3_level, d3_ack}), 128'd0);

        // Reset in the middle of an acked fetch
        push_word(32'h0F0F_0F0F);
        start(32'h0000_0000, 1'b0, 16'hFFFF, '0);
        chk("rm_ack_before", 128'(o_wb_ack), 128'd1);
        #1;
        i_rst = 1'b1;
        mq.delete();
        m_und = 1'b0; m_wadr = '0; m_wsel = '0; m_wdat = '0;
        exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0; exp_wrv = 1'b0;
        pend = 1'b0;
        #1;
        chk("rm_ack_drop", 128'({o_wb_ack, o_wb_err}), 128'd0);
        chk("rm_level",    128'(o_fifo_level), 128'd0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        tick();
        i_rst = 1'b0;
        tick(); tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
